// File: rtl/clk_phase_meter_if.sv
// rtl/clk_phase_meter_if.sv - control, signal inputs and result bundle of the phase meter
interface clk_phase_meter_if #(
  parameter int CNT_W = 16
) ();
  logic             start;
  logic             sig_a;
  logic             sig_b;
  logic             busy;
  logic             meas_valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] lag;
  logic             lag_valid;
  logic             timeout;

  modport master (
    output start, sig_a, sig_b,
    input  busy, meas_valid, period, high_time, lag, lag_valid, timeout
  );

  modport slave (
    input  start, sig_a, sig_b,
    output busy, meas_valid, period, high_time, lag, lag_valid, timeout
  );
endinterface

// File: rtl/clk_phase_meter.sv
// rtl/clk_phase_meter.sv - measures one sig_a period, high time and sig_a-to-sig_b rise lag
module clk_phase_meter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  clk_phase_meter_if.slave mif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_A  = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic                   a_prev_q, b_prev_q;
  logic                   a_cur, b_cur, a_rise, a_fall, b_rise;
  logic                   cnt_at_limit;

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       high_cap_q, high_cap_d;
  logic [CNT_W-1:0]       lag_cap_q, lag_cap_d;
  logic                   high_seen_q, high_seen_d;
  logic                   lag_seen_q, lag_seen_d;
  logic                   busy_q, busy_d;
  logic                   load_out, abort;

  logic                   meas_valid_q;
  logic [CNT_W-1:0]       period_q, high_time_q, lag_q;
  logic                   lag_valid_q, timeout_q;

  // Both inputs see the same pipeline depth, so the latency cancels in every difference.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      a_prev_q <= 1'b0;
      b_prev_q <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], mif.sig_a};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], mif.sig_b};
      a_prev_q <= a_cur;
      b_prev_q <= b_cur;
    end
  end

  assign a_cur        = a_sync_q[SYNC_STAGES-1];
  assign b_cur        = b_sync_q[SYNC_STAGES-1];
  assign a_rise       = a_cur & ~a_prev_q;
  assign a_fall       = ~a_cur & a_prev_q;
  assign b_rise       = b_cur & ~b_prev_q;
  assign cnt_at_limit = (cnt_q == CNT_LAST);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (mif.start) state_d = S_WAIT_A;
      S_WAIT_A:  if (a_rise) state_d = S_MEASURE;
                 else if (cnt_at_limit) state_d = S_DONE;
      S_MEASURE: if (a_rise || cnt_at_limit) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    high_cap_d  = high_cap_q;
    high_seen_d = high_seen_q;
    lag_cap_d   = lag_cap_q;
    lag_seen_d  = lag_seen_q;
    busy_d      = busy_q;
    load_out    = 1'b0;
    abort       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mif.start) begin
          busy_d      = 1'b1;
          cnt_d       = '0;
          high_cap_d  = '0;
          high_seen_d = 1'b0;
          lag_cap_d   = '0;
          lag_seen_d  = 1'b0;
        end
      end
      S_WAIT_A: begin
        cnt_d = cnt_q + CNT_ONE;
        if (a_rise) begin
          cnt_d = CNT_ONE;
          if (b_rise) begin
            lag_cap_d  = '0;
            lag_seen_d = 1'b1;
          end
        end else if (cnt_at_limit) begin
          abort    = 1'b1;
          load_out = 1'b1;
          busy_d   = 1'b0;
        end
      end
      S_MEASURE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (a_fall && !high_seen_q) begin
          high_cap_d  = cnt_q;
          high_seen_d = 1'b1;
        end
        // A sig_b rise coincident with the closing sig_a rise belongs to the next period.
        if (b_rise && !lag_seen_q && !a_rise) begin
          lag_cap_d  = cnt_q;
          lag_seen_d = 1'b1;
        end
        if (a_rise) begin
          load_out = 1'b1;
          busy_d   = 1'b0;
        end else if (cnt_at_limit) begin
          abort    = 1'b1;
          load_out = 1'b1;
          busy_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q        <= '0;
      high_cap_q   <= '0;
      high_seen_q  <= 1'b0;
      lag_cap_q    <= '0;
      lag_seen_q   <= 1'b0;
      busy_q       <= 1'b0;
      meas_valid_q <= 1'b0;
      period_q     <= '0;
      high_time_q  <= '0;
      lag_q        <= '0;
      lag_valid_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      high_cap_q   <= high_cap_d;
      high_seen_q  <= high_seen_d;
      lag_cap_q    <= lag_cap_d;
      lag_seen_q   <= lag_seen_d;
      busy_q       <= busy_d;
      meas_valid_q <= load_out;
      if (load_out) begin
        period_q    <= abort ? '0 : cnt_q;
        high_time_q <= (abort || !high_seen_d) ? '0 : high_cap_d;
        lag_q       <= lag_cap_d;
        lag_valid_q <= lag_seen_d;
        timeout_q   <= abort;
      end
    end
  end

  assign mif.busy       = busy_q;
  assign mif.meas_valid = meas_valid_q;
  assign mif.period     = period_q;
  assign mif.high_time  = high_time_q;
  assign mif.lag        = lag_q;
  assign mif.lag_valid  = lag_valid_q;
  assign mif.timeout    = timeout_q;

endmodule

// File: tb/tb_clk_phase_meter.sv
// tb/tb_clk_phase_meter.sv - directed and randomized waveform bench for clk_phase_meter
module tb_clk_phase_meter;
  localparam int CNT_W = 16;
  localparam int TO    = 100;
  localparam int LIMIT = 1000;

  typedef struct {
    int period;
    int high;
    int lag;
    int lv;
    int to;
  } exp_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  clk_phase_meter_if #(.CNT_W(CNT_W)) mif ();

  clk_phase_meter #(
    .SYNC_STAGES (2),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .mif       (mif)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int t      = 1000;
  bit cfg_a_on;
  int cfg_p, cfg_h, cfg_d, cfg_b_mode, cfg_bp, cfg_bh;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // sig_a: period cfg_p, high cfg_h; sig_b: delayed copy (0), held low (1) or independent (2).
  task automatic drive_wave();
    mif.sig_a = cfg_a_on && ((t % cfg_p) < cfg_h);
    case (cfg_b_mode)
      0:       mif.sig_b = cfg_a_on && (((t - cfg_d) % cfg_p) < cfg_h);
      2:       mif.sig_b = ((t % cfg_bp) < cfg_bh);
      default: mif.sig_b = 1'b0;
    endcase
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    t++;
    drive_wave();
  endtask

  task automatic set_cfg(input bit a_on, input int p, input int h, input int d, input int bmode);
    cfg_a_on   = a_on;
    cfg_p      = p;
    cfg_h      = h;
    cfg_d      = d;
    cfg_b_mode = bmode;
    repeat (4) step();
  endtask

  function automatic exp_t model();
    exp_t e;
    e = '{default: 0};
    if (cfg_a_on) begin
      if (cfg_b_mode == 0 && (cfg_d % cfg_p) <= TO - 1) begin
        e.lag = cfg_d % cfg_p;
        e.lv  = 1;
      end
      if (cfg_p < TO) begin
        e.period = cfg_p;
        e.high   = cfg_h;
      end else begin
        e.to = 1;
      end
    end else begin
      e.to = 1;
    end
    return e;
  endfunction

  task automatic check_fields(input string tag, input exp_t e);
    check({tag, ".period"}, 32'(mif.period), e.period);
    check({tag, ".high"}, 32'(mif.high_time), e.high);
    check({tag, ".lag"}, 32'(mif.lag), e.lag);
    check({tag, ".lag_valid"}, 32'(mif.lag_valid), e.lv);
    check({tag, ".timeout"}, 32'(mif.timeout), e.to);
  endtask

  task automatic run_meas(input string tag, input bit poke, input bit timed);
    exp_t e;
    int   cyc;
    int   extra;
    e = model();
    if (cfg_a_on) while (((t + 4) % cfg_p) != 0) step();
    mif.start = 1'b1;
    step();
    mif.start = 1'b0;
    check({tag, ".busy"}, 32'(mif.busy), 1);
    cyc = 0;
    if (poke) begin
      step();
      step();
      mif.start = 1'b1;
      step();
      mif.start = 1'b0;
      cyc = 3;
    end
    while (mif.meas_valid !== 1'b1 && cyc < LIMIT) begin
      step();
      cyc++;
    end
    check({tag, ".valid_seen"}, 32'(cyc < LIMIT), 1);
    if (timed) check({tag, ".timeout_cycles"}, cyc, TO);
    check_fields(tag, e);
    if (poke) begin
      mif.start = 1'b1;
      step();
      mif.start = 1'b0;
      check({tag, ".busy_after_done"}, 32'(mif.busy), 0);
      extra = 0;
      repeat (30) begin
        step();
        if (mif.meas_valid === 1'b1) extra++;
      end
      check({tag, ".extra_valid"}, extra, 0);
      check_fields({tag, ".hold"}, e);
    end
  endtask

  initial begin
    int mode;
    mif.start = 1'b0;
    cfg_bp    = 7;
    cfg_bh    = 3;
    cfg_a_on  = 1'b1;
    cfg_p     = 10;
    cfg_h     = 4;
    cfg_d     = 3;
    cfg_b_mode = 0;
    drive_wave();
    repeat (3) step();
    check("reset.busy", 32'(mif.busy), 0);
    check("reset.valid", 32'(mif.meas_valid), 0);
    check_fields("reset", '{default: 0});
    sys_rst_n = 1'b1;
    step();

    set_cfg(1, 10, 4, 3, 0);   run_meas("s1_lag3", 0, 0);
    set_cfg(1, 10, 4, 0, 0);   run_meas("s2_same", 0, 0);
    set_cfg(1, 12, 6, 0, 1);   run_meas("s3_b_low", 0, 0);
    set_cfg(0, 10, 4, 0, 2);   run_meas("s4_a_low", 0, 1);

    // Reset in the middle of a long measurement.
    set_cfg(1, 60, 20, 7, 0);
    while (((t + 4) % cfg_p) != 0) step();
    mif.start = 1'b1;
    step();
    mif.start = 1'b0;
    repeat (35) step();
    check("s5.busy_before", 32'(mif.busy), 1);
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    check("s5.busy", 32'(mif.busy), 0);
    check("s5.valid", 32'(mif.meas_valid), 0);
    check_fields("s5", '{default: 0});
    set_cfg(1, 10, 4, 3, 0);   run_meas("s5_rerun", 0, 0);

    set_cfg(1, 16, 9, 11, 0);  run_meas("s6_poke", 1, 0);
    set_cfg(1, 99, 50, 98, 0); run_meas("b_p99", 0, 0);
    set_cfg(1, 100, 30, 40, 0); run_meas("b_p100", 0, 0);
    set_cfg(1, 12, 5, 12, 0);  run_meas("b_d_eq_p", 0, 0);
    set_cfg(1, 8, 1, 7, 0);    run_meas("b_h1", 0, 0);
    set_cfg(1, 8, 7, 1, 0);    run_meas("b_hmax", 0, 0);

    for (int i = 0; i < 12; i++) begin
      mode   = int'($urandom_range(4, 0));
      cfg_p  = int'($urandom_range(40, 4));
      cfg_h  = int'($urandom_range(cfg_p - 1, 1));
      cfg_d  = int'($urandom_range(cfg_p, 0));
      cfg_bp = int'($urandom_range(20, 3));
      cfg_bh = int'($urandom_range(cfg_bp - 1, 1));
      if (mode <= 2) begin
        set_cfg(1, cfg_p, cfg_h, cfg_d, 0);
        run_meas($sformatf("rnd%0d_copy", i), (mode == 2), 0);
      end else if (mode == 3) begin
        set_cfg(1, cfg_p, cfg_h, cfg_d, 1);
        run_meas($sformatf("rnd%0d_blow", i), 0, 0);
      end else begin
        set_cfg(0, cfg_p, cfg_h, cfg_d, 2);
        run_meas($sformatf("rnd%0d_alow", i), 0, 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clk_phase_meter.md
Name: clk_phase_meter

Overview:
Single-clock measurement block that samples two asynchronous periodic signals, a reference (sig_a) and a lagging copy (sig_b), for example the 33 MHz clock and its phase-shifted twin from the clock wizard. Runs in the sys_clk domain, which must be several times faster than the measured signals. On each start request it measures one full sig_a period: period, high time, and the sig_a-rise to sig_b-rise lag, all in sys_clk cycles. Results feed on-chip debug or ILA probes and allow a self-check of the wizard phase setting without external equipment.

Parameters:
SYNC_STAGES, 2, synchronizer flip-flop depth applied to sig_a and sig_b (minimum 2).
CNT_W, 16, width of the cycle counter and of all result fields.
TIMEOUT_CYC, 65535, maximum cycles allowed in WAIT_A or MEASURE before abort; must be at most 2^CNT_W-1.

Ports:
sys_clk  in  1  sole clock; all logic on its rising edge.
sys_rst_n  in  1  synchronous active-low reset.
start  in  1  one-cycle request to begin a measurement; ignored while busy=1.
sig_a  in  1  asynchronous reference signal.
sig_b  in  1  asynchronous lagging signal.
busy  out  1  high from the cycle after an accepted start until meas_valid.
meas_valid  out  1  one-cycle pulse when the result fields update.
period  out  CNT_W  sig_a rise-to-rise in cycles; 0 on timeout.
high_time  out  CNT_W  sig_a rise-to-fall in cycles; 0 on timeout or if no fall seen.
lag  out  CNT_W  sig_a rise to first sig_b rise in cycles.
lag_valid  out  1  1 if a sig_b rise occurred inside the measured period.
timeout  out  1  1 if the last measurement aborted.

Behaviour:
- Reset (sys_rst_n=0 at a clock edge): state goes to IDLE. All outputs and the counter are 0. Synchronizer and edge-detect history are cleared to 0. Reset mid-measurement discards partial results.
- Both inputs use identical SYNC_STAGES synchronizers plus one edge-detect register. The fixed latency cancels in every difference measured.
- Edge detect: rise = cur & ~prev; fall = ~cur & prev, computed on the synchronized values.
- States:
  - IDLE: start=1 -> WAIT_A, busy<=1, counter<=0, internal flags cleared.
  - WAIT_A: counter increments each cycle. On a_rise: counter<=1, go to MEASURE. If b_rise is in the same cycle, lag<=0 and lag seen. If counter reaches TIMEOUT_CYC first, go to DONE with timeout.
  - MEASURE: counter increments each cycle; the value recorded at an event is the counter value in that cycle.
    - First a_fall: capture high_time.
    - First b_rise, if lag not yet seen: capture lag.
    - a_rise: capture period, go to DONE.
    - Simultaneous a_rise and b_rise with lag not seen: b_rise belongs to the next period, so lag is not captured.
    - Simultaneous a_fall and b_rise: both captured.
    - Counter reaching TIMEOUT_CYC: go to DONE with timeout.
  - DONE (one cycle): output registers load, meas_valid=1, busy<=0, next state IDLE.
    - timeout=1 forces period=0 and high_time=0; lag and lag_valid still reflect any capture.
    - An uncaptured high_time reports 0.
- Outputs hold between measurements. A start arriving in the DONE cycle is ignored; it is accepted only in IDLE.
- The counter never wraps; the timeout bound prevents it.
- Accuracy: ±1 cycle per edge due to asynchronous sampling.

Test Plan:
1. sig_a period 10 cycles, high 4, sig_b = sig_a delayed 3 cycles; pulse start -> meas_valid once, period=10, high_time=4, lag=3, lag_valid=1, timeout=0.
2. sig_b identical to sig_a -> lag=0, lag_valid=1, period=10.
3. sig_b held 0, sig_a period 12, high 6 -> period=12, high_time=6, lag_valid=0, lag=0.
4. sig_a held 0, TIMEOUT_CYC=100 -> meas_valid exactly TIMEOUT_CYC cycles after entering WAIT_A, timeout=1, period=0, high_time=0.
5. Assert sys_rst_n=0 for one cycle mid-MEASURE -> next cycle busy=0 and all outputs 0. A new start then gives the correct result as in scenario 1.
6. Second start pulse while busy=1 -> ignored, exactly one meas_valid produced. Results from a previous run hold unchanged until the next meas_valid.
